// File: rtl/mem_stage_lsu_pkg.sv
// definitions: shared memory-access types and helpers for the MEM-stage load/store unit
package definitions;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_access_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP,
        LSU_DONE
    } lsu_state_t;

    // Encoding 2'b11 falls through to the word case everywhere below.
    function automatic logic mem_access_is_misaligned(logic [1:0] addr, logic [1:0] size);
        return size == SIZE_BYTE ? 1'b0 : size == SIZE_HALF ? addr[0] : |addr;
    endfunction

    function automatic logic [3:0] mem_access_byte_enable(logic [1:0] addr, logic [1:0] size);
        return size == SIZE_BYTE ? 4'b0001 << addr : size == SIZE_HALF ? 4'b0011 << addr : 4'b1111;
    endfunction

    function automatic logic [31:0] mem_access_store_data(logic [31:0] data, logic [1:0] size);
        return size == SIZE_BYTE ? {4{data[7:0]}} : size == SIZE_HALF ? {2{data[15:0]}} : data;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_aligner.sv
// load_data_aligner: shifts the response word to the accessed lane and extends it
module load_data_aligner
    import definitions::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);
    logic [31:0] sh;
    always_comb begin
        sh = rdata_i >> {offset_i, 3'b000};
        data_o = size_i == SIZE_BYTE ? {{24{signed_i & sh[7]}}, sh[7:0]}
               : size_i == SIZE_HALF ? {{16{signed_i & sh[15]}}, sh[15:0]}
               : sh;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store FSM driving a valid/ready data-memory port
module mem_stage_lsu
    import definitions::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    input  logic        is_store_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [1:0]  size_i,
    input  logic        rd_signed_i,
    output logic        stall_o,
    output logic [31:0] rd_data_o,
    output logic        rd_data_valid_o,
    output logic        misaligned_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic [31:0] dmem_req_addr_o,
    output logic        dmem_req_we_o,
    output logic [3:0]  dmem_req_be_o,
    output logic [31:0] dmem_req_wdata_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [31:0] dmem_rsp_rdata_i
);
    lsu_state_t  state, state_nx;
    logic [31:0] addr_q, wdata_q, load_word;
    logic [3:0]  be_q;
    logic [1:0]  size_q;
    logic        store_q, signed_q, aligned, accept;

    load_data_aligner u_align (
        .rdata_i  (dmem_rsp_rdata_i),
        .offset_i (addr_q[1:0]),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (load_word)
    );

    always_comb begin
        aligned = !mem_access_is_misaligned(addr_i[1:0], size_i);
        accept = state == LSU_IDLE && req_valid_i && aligned;
        state_nx = state;
        case (state)
            LSU_IDLE:     state_nx = accept ? LSU_REQ : LSU_IDLE;
            LSU_REQ:      state_nx = !dmem_req_ready_i ? LSU_REQ : store_q ? LSU_DONE : LSU_WAIT_RSP;
            LSU_WAIT_RSP: state_nx = dmem_rsp_valid_i ? LSU_DONE : LSU_WAIT_RSP;
            default:      state_nx = LSU_IDLE;
        endcase
    end

    // Reset masks the combinational request-side outputs so it dominates req_valid_i.
    assign stall_o          = !reset_i && (state == LSU_IDLE ? req_valid_i && aligned : state != LSU_DONE);
    assign misaligned_o     = !reset_i && state == LSU_IDLE && req_valid_i && !aligned;
    assign rd_data_valid_o  = state == LSU_DONE && !store_q;
    assign dmem_req_valid_o = state == LSU_REQ;
    assign dmem_req_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_req_we_o    = store_q;
    assign dmem_req_be_o    = be_q;
    assign dmem_req_wdata_o = wdata_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= LSU_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            size_q    <= '0;
            store_q   <= 1'b0;
            signed_q  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q   <= addr_i;
                wdata_q  <= mem_access_store_data(wr_data_i, size_i);
                be_q     <= is_store_i ? mem_access_byte_enable(addr_i[1:0], size_i) : 4'b1111;
                size_q   <= size_i;
                store_q  <= is_store_i;
                signed_q <= rd_signed_i;
            end
            if (state == LSU_WAIT_RSP && dmem_rsp_valid_i)
                rd_data_o <= load_word;
        end
    end
endmodule
